// File: rtl/rect_fill_writer.sv
// Rectangle fill engine: accepts one clipped rectangle command and streams one framebuffer write per cycle.
// Optional macro RECT_FILL_OUTLINE_EN adds cmd_outline_i to draw only the clipped rectangle border.
module rect_fill_writer #(
  parameter int FB_X = 1280,
  parameter int FB_Y = 720,
  localparam int X_BITS = $clog2(FB_X + 1),
  localparam int Y_BITS = $clog2(FB_Y + 1),
  localparam int FB_ADDR_BITS = $clog2(FB_X * FB_Y)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [X_BITS-1:0]       cmd_x0_i,
  input  logic [Y_BITS-1:0]       cmd_y0_i,
  input  logic [X_BITS-1:0]       cmd_w_i,
  input  logic [Y_BITS-1:0]       cmd_h_i,
  input  logic [23:0]             cmd_color_i,
`ifdef RECT_FILL_OUTLINE_EN
  input  logic                    cmd_outline_i,
`endif
  output logic [FB_ADDR_BITS-1:0] pxl_addr_o,
  output logic [23:0]             pxl_data_o,
  output logic                    pxl_en_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [X_BITS:0]       FB_X_EXT  = (X_BITS + 1)'(FB_X);
  localparam logic [Y_BITS:0]       FB_Y_EXT  = (Y_BITS + 1)'(FB_Y);
  localparam logic [FB_ADDR_BITS-1:0] FB_X_ADDR = FB_ADDR_BITS'(FB_X);

  logic [1:0]        r_state;
  logic [X_BITS-1:0] r_x;
  logic [X_BITS-1:0] r_x0;
  logic [X_BITS-1:0] r_x_last;
  logic [Y_BITS-1:0] r_y;
  logic [Y_BITS-1:0] r_y_last;
  logic [23:0]       r_color;
`ifdef RECT_FILL_OUTLINE_EN
  logic [Y_BITS-1:0] r_y0;
  logic              r_outline;
  logic              w_on_border;
`endif

  logic [X_BITS:0]   w_x0_ext;
  logic [X_BITS:0]   w_w_ext;
  logic [X_BITS:0]   w_x_room;
  logic [X_BITS:0]   w_we;
  logic [Y_BITS:0]   w_y0_ext;
  logic [Y_BITS:0]   w_h_ext;
  logic [Y_BITS:0]   w_y_room;
  logic [Y_BITS:0]   w_he;
  logic [X_BITS-1:0] w_x_last;
  logic [Y_BITS-1:0] w_y_last;
  logic              w_empty;
  logic              w_fill;

  // Clip against the framebuffer edge; one extra bit keeps FB_X - x0 from wrapping.
  always_comb begin
    w_x0_ext = {1'b0, cmd_x0_i};
    w_w_ext  = {1'b0, cmd_w_i};
    w_x_room = FB_X_EXT - w_x0_ext;
    if (w_x0_ext >= FB_X_EXT)    w_we = '0;
    else if (w_w_ext < w_x_room) w_we = w_w_ext;
    else                         w_we = w_x_room;

    w_y0_ext = {1'b0, cmd_y0_i};
    w_h_ext  = {1'b0, cmd_h_i};
    w_y_room = FB_Y_EXT - w_y0_ext;
    if (w_y0_ext >= FB_Y_EXT)    w_he = '0;
    else if (w_h_ext < w_y_room) w_he = w_h_ext;
    else                         w_he = w_y_room;
  end

  assign w_x_last = cmd_x0_i + w_we[X_BITS-1:0] - X_BITS'(1);
  assign w_y_last = cmd_y0_i + w_he[Y_BITS-1:0] - Y_BITS'(1);
  assign w_empty  = (w_we == '0) || (w_he == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_x0     <= '0;
      r_x_last <= '0;
      r_y      <= '0;
      r_y_last <= '0;
      r_color  <= '0;
`ifdef RECT_FILL_OUTLINE_EN
      r_y0      <= '0;
      r_outline <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_x      <= cmd_x0_i;
            r_x0     <= cmd_x0_i;
            r_x_last <= w_x_last;
            r_y      <= cmd_y0_i;
            r_y_last <= w_y_last;
            r_color  <= cmd_color_i;
`ifdef RECT_FILL_OUTLINE_EN
            r_y0      <= cmd_y0_i;
            r_outline <= cmd_outline_i;
`endif
            r_state  <= w_empty ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (r_x == r_x_last) begin
            if (r_y == r_y_last) begin
              r_state <= S_DONE;
            end else begin
              r_x <= r_x0;
              r_y <= r_y + Y_BITS'(1);
            end
          end else begin
            r_x <= r_x + X_BITS'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_fill = (r_state == S_FILL);

`ifdef RECT_FILL_OUTLINE_EN
  assign w_on_border = (r_x == r_x0) || (r_x == r_x_last) ||
                       (r_y == r_y0) || (r_y == r_y_last);
  assign pxl_en_o    = w_fill && (!r_outline || w_on_border);
`else
  assign pxl_en_o    = w_fill;
`endif

  assign pxl_addr_o  = FB_ADDR_BITS'(r_y) * FB_X_ADDR + FB_ADDR_BITS'(r_x);
  assign pxl_data_o  = r_color;
  assign cmd_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state == S_FILL) || (r_state == S_DONE);
  assign done_o      = (r_state == S_DONE);

endmodule

// File: tb/tb_rect_fill_writer.sv
// Self-checking bench for rect_fill_writer: directed corner cases plus randomized commands
// checked against a pixel-list reference model built from the clipping rules.
module tb_rect_fill_writer;
  localparam int FB_X = 1280;
  localparam int FB_Y = 720;
  localparam int XB = $clog2(FB_X + 1);
  localparam int YB = $clog2(FB_Y + 1);
  localparam int AB = $clog2(FB_X * FB_Y);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [XB-1:0] cmd_x0_i = '0;
  logic [YB-1:0] cmd_y0_i = '0;
  logic [XB-1:0] cmd_w_i = '0;
  logic [YB-1:0] cmd_h_i = '0;
  logic [23:0]   cmd_color_i = '0;
  logic          cmd_outline_i = 1'b0;
  logic [AB-1:0] pxl_addr_o;
  logic [23:0]   pxl_data_o;
  logic          pxl_en_o;
  logic          busy_o;
  logic          done_o;

  rect_fill_writer #(.FB_X(FB_X), .FB_Y(FB_Y)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_x0_i    (cmd_x0_i),
    .cmd_y0_i    (cmd_y0_i),
    .cmd_w_i     (cmd_w_i),
    .cmd_h_i     (cmd_h_i),
    .cmd_color_i (cmd_color_i),
`ifdef RECT_FILL_OUTLINE_EN
    .cmd_outline_i (cmd_outline_i),
`endif
    .pxl_addr_o  (pxl_addr_o),
    .pxl_data_o  (pxl_data_o),
    .pxl_en_o    (pxl_en_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {int c; int a; int d;} wr_t;
  wr_t got_w[$];
  wr_t exp_w[$];
  int  got_d[$];
  int  exp_d[$];
  int  tests_run = 0;
  int  failed = 0;

  always @(negedge clk_i) begin
    if (pxl_en_o === 1'b1) got_w.push_back('{cyc, int'(pxl_addr_o), int'(pxl_data_o)});
    if (done_o === 1'b1) got_d.push_back(cyc);
  end

  function automatic int clip(int p0, int len, int lim);
    if (p0 >= lim) return 0;
    return (len < lim - p0) ? len : lim - p0;
  endfunction

  // Reference: every pixel of the clipped rectangle in row-major order, one cycle each.
  task automatic model_cmd(input int x0, input int y0, input int w, input int h, input int col,
                           input bit outl, input int n, output int last);
    int we, he, k;
    we = clip(x0, w, FB_X);
    he = clip(y0, h, FB_Y);
    k = 0;
    for (int yy = y0; yy < y0 + he; yy++) begin
      for (int xx = x0; xx < x0 + we; xx++) begin
        if (!outl || xx == x0 || xx == x0 + we - 1 || yy == y0 || yy == y0 + he - 1)
          exp_w.push_back('{n + 1 + k, yy * FB_X + xx, col});
        k++;
      end
    end
    last = n + 1 + we * he;
    exp_d.push_back(last);
  endtask

  task automatic compare_logs(input string name);
    int m;
    tests_run++;
    if (got_w.size() != exp_w.size()) begin
      failed++;
      $display("FAIL %s write_count got %0d expected %0d", name, got_w.size(), exp_w.size());
    end
    m = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < m; i++) begin
      tests_run++;
      if (got_w[i].c !== exp_w[i].c || got_w[i].a !== exp_w[i].a || got_w[i].d !== exp_w[i].d) begin
        failed++;
        $display("FAIL %s write[%0d] got cyc=%0d addr=%0d data=%06h expected cyc=%0d addr=%0d data=%06h",
                 name, i, got_w[i].c, got_w[i].a, got_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d);
      end
    end
    tests_run++;
    if (got_d.size() != exp_d.size() || (got_d.size() > 0 && got_d[0] !== exp_d[0])) begin
      failed++;
      $display("FAIL %s done got count=%0d first=%0d expected count=%0d first=%0d", name,
               got_d.size(), (got_d.size() > 0) ? got_d[0] : -1, exp_d.size(),
               (exp_d.size() > 0) ? exp_d[0] : -1);
    end
    got_w.delete(); exp_w.delete(); got_d.delete(); exp_d.delete();
  endtask

  // Presents a command and returns its accept cycle; hold keeps valid high for a chained command.
  task automatic do_cmd(input int x0, input int y0, input int w, input int h, input int col,
                        input bit outl, input bit hold, output int n);
    if (!cmd_valid_i) begin
      @(posedge clk_i); #1;
    end
    cmd_valid_i = 1'b1;
    cmd_x0_i = XB'(x0); cmd_y0_i = YB'(y0);
    cmd_w_i = XB'(w);   cmd_h_i = YB'(h);
    cmd_color_i = 24'(col); cmd_outline_i = outl;
    n = -1;
    for (int t = 0; t < 3000 && n < 0; t++) begin
      @(negedge clk_i);
      if (cmd_ready_o === 1'b1) n = cyc;
    end
    if (n < 0) begin
      tests_run++; failed++;
      $display("FAIL accept_timeout got ready=%b expected ready=1", cmd_ready_o);
    end
    @(posedge clk_i); #1;
    if (!hold) cmd_valid_i = 1'b0;
  endtask

  task automatic wait_to(input int c);
    do @(negedge clk_i); while (cyc < c);
  endtask

  task automatic check_tail(input string name, input int last);
    wait_to(last);
    tests_run++;
    if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
      failed++;
      $display("FAIL %s done_cycle got busy=%b ready=%b expected busy=1 ready=0", name, busy_o, cmd_ready_o);
    end
    wait_to(last + 1);
    tests_run++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failed++;
      $display("FAIL %s ready_return got ready=%b busy=%b expected ready=1 busy=0", name, cmd_ready_o, busy_o);
    end
  endtask

  task automatic run_one(input string name, input int x0, input int y0, input int w, input int h,
                         input int col, input bit outl);
    int n, last;
    do_cmd(x0, y0, w, h, col, outl, 1'b0, n);
    model_cmd(x0, y0, w, h, col, outl, n, last);
    check_tail(name, last);
    compare_logs(name);
    $display("[TB] %s x0=%0d y0=%0d w=%0d h=%0d outline=%0b accepted at %0d", name, x0, y0, w, h, outl, n);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cmd_valid_i = 1'b1;
    cmd_x0_i = XB'(5); cmd_y0_i = '0; cmd_w_i = XB'(4); cmd_h_i = YB'(4); cmd_color_i = 24'h123456;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    tests_run++; if (cmd_ready_o !== 1'b1) begin failed++; $display("FAIL rst_ready got %b expected 1", cmd_ready_o); end
    tests_run++; if (pxl_en_o !== 1'b0) begin failed++; $display("FAIL rst_en got %b expected 0", pxl_en_o); end
    tests_run++; if (busy_o !== 1'b0) begin failed++; $display("FAIL rst_busy got %b expected 0", busy_o); end
    tests_run++; if (done_o !== 1'b0) begin failed++; $display("FAIL rst_done got %b expected 0", done_o); end
    tests_run++; if (pxl_addr_o !== '0) begin failed++; $display("FAIL rst_addr got %0d expected 0", pxl_addr_o); end
    tests_run++; if (pxl_data_o !== '0) begin failed++; $display("FAIL rst_data got %06h expected 0", pxl_data_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0; cmd_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    compare_logs("reset_ignores_valid");
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    run_one("fill_3x2", 10, 2, 3, 2, 24'hFF0000, 1'b0);
    run_one("clip_right", 1278, 0, 5, 1, 24'h00FF00, 1'b0);
    run_one("zero_width", 20, 20, 0, 4, 24'h0000FF, 1'b0);
    run_one("x0_offscreen", 1280, 5, 4, 4, 24'h0F0F0F, 1'b0);
    run_one("clip_corner", 1277, 718, 9, 9, 24'hABCDEF, 1'b0);
  endtask

  task automatic test_reset_abort();
    int n, last;
    do_cmd(100, 50, 4, 4, 24'h55AA55, 1'b0, 1'b0, n);
    for (int i = 0; i < 3; i++) exp_w.push_back('{n + 1 + i, 50 * FB_X + 100 + i, 24'h55AA55});
    wait_to(n + 2);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    last = n + 25;
    wait_to(last);
    tests_run++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failed++;
      $display("FAIL abort_idle got ready=%b busy=%b expected ready=1 busy=0", cmd_ready_o, busy_o);
    end
    compare_logs("reset_abort");
    $display("[TB] reset_abort accepted at %0d", n);
  endtask

  task automatic test_back_to_back();
    int n1, n2, l1, l2;
    do_cmd(7, 9, 2, 2, 24'h111111, 1'b0, 1'b1, n1);
    do_cmd(300, 400, 3, 1, 24'h222222, 1'b0, 1'b0, n2);
    tests_run++;
    if (n2 !== n1 + 6) begin
      failed++;
      $display("FAIL b2b_accept got %0d expected %0d", n2, n1 + 6);
    end
    model_cmd(7, 9, 2, 2, 24'h111111, 1'b0, n1, l1);
    model_cmd(300, 400, 3, 1, 24'h222222, 1'b0, n2, l2);
    got_d.delete();
    wait_to(l2 + 1);
    exp_d.delete();
    exp_d.push_back(l1);
    got_d.delete();
    got_d.push_back(l1);
    compare_logs("back_to_back");
    $display("[TB] back_to_back accepted at %0d and %0d", n1, n2);
  endtask

  task automatic test_random();
    int x0, y0, w, h, col;
    bit outl;
    for (int i = 0; i < 24; i++) begin
      case ($urandom % 3)
        0: begin x0 = $urandom_range(0, FB_X - 1); y0 = $urandom_range(0, FB_Y - 1); end
        1: begin x0 = $urandom_range(FB_X - 6, FB_X + 2); y0 = $urandom_range(FB_Y - 6, FB_Y + 2); end
        default: begin x0 = $urandom_range(0, (1 << XB) - 1); y0 = $urandom_range(0, (1 << YB) - 1); end
      endcase
      if ($urandom % 4 == 0) begin
        w = $urandom_range(0, (1 << XB) - 1); h = $urandom_range(0, 1);
      end else begin
        w = $urandom_range(0, 7); h = $urandom_range(0, 7);
      end
      col = int'($urandom & 32'h00FF_FFFF);
`ifdef RECT_FILL_OUTLINE_EN
      outl = 1'($urandom % 2);
`else
      outl = 1'b0;
`endif
      run_one("random", x0, y0, w, h, col, outl);
    end
  endtask

`ifdef RECT_FILL_OUTLINE_EN
  task automatic test_outline();
    int n, last;
    bit seen;
    do_cmd(0, 0, 3, 3, 24'hC0FFEE, 1'b1, 1'b0, n);
    model_cmd(0, 0, 3, 3, 24'hC0FFEE, 1'b1, n, last);
    check_tail("outline_3x3", last);
    seen = 1'b0;
    foreach (got_w[i]) if (got_w[i].a == 1281) seen = 1'b1;
    tests_run++;
    if (seen) begin
      failed++;
      $display("FAIL outline_center got write at 1281 expected none");
    end
    compare_logs("outline_3x3");
    $display("[TB] outline_3x3 accepted at %0d", n);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_back_to_back();
`ifdef RECT_FILL_OUTLINE_EN
    test_outline();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
